// File: rtl/sample_deinterleave_4out.sv
// Serial-to-parallel lane distributor: groups four samples into D0..D3.
// One output register plus one staging group keeps full rate under stall.
module sample_deinterleave_4out #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    input  logic             sync_i,
    output logic [WIDTH-1:0] D0_o,
    output logic [WIDTH-1:0] D1_o,
    output logic [WIDTH-1:0] D2_o,
    output logic [WIDTH-1:0] D3_o,
    output logic             q_valid_o,
    input  logic             q_ready_i,
    output logic [CNT_W-1:0] grp_cnt_o
);

    logic [1:0]       lane_q, lane_d;
    logic [WIDTH-1:0] stg_q [4];
    logic [WIDTH-1:0] stg_d [4];
    logic [WIDTH-1:0] out_q [4];
    logic [WIDTH-1:0] out_d [4];
    logic             full_q, full_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             slot_free;
    logic             hs;
    logic [1:0]       eff_lane;

    assign accept    = din_valid_i && !full_q;
    assign slot_free = !vld_q || q_ready_i;
    assign hs        = vld_q && q_ready_i;
    assign eff_lane  = sync_i ? 2'd0 : lane_q;

    // Next-state: lane steering, group completion, staging and drain.
    always_comb begin
        lane_d = lane_q;
        stg_d  = stg_q;
        out_d  = out_q;
        full_d = full_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;

        if (hs) begin
            cnt_d = cnt_q + CNT_W'(1);
            vld_d = 1'b0;
        end

        if (sync_i) begin
            lane_d = accept ? 2'd1 : 2'd0;
        end else if (accept) begin
            lane_d = lane_q + 2'd1;
        end

        if (full_q && slot_free) begin
            out_d  = stg_q;
            vld_d  = 1'b1;
            full_d = 1'b0;
        end else if (accept && eff_lane == 2'd3) begin
            if (slot_free) begin
                out_d[0] = stg_q[0];
                out_d[1] = stg_q[1];
                out_d[2] = stg_q[2];
                out_d[3] = din_i;
                vld_d    = 1'b1;
            end else begin
                stg_d[3] = din_i;
                full_d   = 1'b1;
            end
        end else if (accept) begin
            stg_d[eff_lane] = din_i;
        end
    end

    // State registers; reset drops any partial or held group.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_q <= 2'd0;
            full_q <= 1'b0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                stg_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            lane_q <= lane_d;
            full_q <= full_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            stg_q  <= stg_d;
            out_q  <= out_d;
        end
    end

    assign din_ready_o = !full_q;
    assign D0_o        = out_q[0];
    assign D1_o        = out_q[1];
    assign D2_o        = out_q[2];
    assign D3_o        = out_q[3];
    assign q_valid_o   = vld_q;
    assign grp_cnt_o   = cnt_q;

endmodule

// File: tb/tb_sample_deinterleave_4out.sv
// Scoreboard bench for sample_deinterleave_4out.
// Groups are predicted from a sample-list model and checked on each handoff.
module tb_sample_deinterleave_4out;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef logic [4*W-1:0] grp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [W-1:0]  din_i = '0;
    logic          din_valid_i = 1'b0;
    logic          din_ready_o;
    logic          sync_i = 1'b0;
    logic [W-1:0]  D0_o, D1_o, D2_o, D3_o;
    logic          q_valid_o;
    logic          q_ready_i = 1'b0;
    logic [CW-1:0] grp_cnt_o;

    int pass_cnt = 0;
    int total = 0;

    logic [W-1:0]  part[$];
    grp_t          exp_q[$];
    logic [CW-1:0] exp_cnt = '0;

    sample_deinterleave_4out #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_i      (din_i),
        .din_valid_i(din_valid_i),
        .din_ready_o(din_ready_o),
        .sync_i     (sync_i),
        .D0_o       (D0_o),
        .D1_o       (D1_o),
        .D2_o       (D2_o),
        .D3_o       (D3_o),
        .q_valid_o  (q_valid_o),
        .q_ready_i  (q_ready_i),
        .grp_cnt_o  (grp_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        total++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    function automatic grp_t mk(input int a, input int b,
                                input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    // Reference: list of samples since the last boundary; four make a group.
    function automatic void model_take(input logic [W-1:0] x, input bit s);
        if (s) part.delete();
        part.push_back(x);
        if (part.size() == 4) begin
            exp_q.push_back({part[3], part[2], part[1], part[0]});
            part.delete();
        end
    endfunction

    task automatic cyc(input bit v, input int x, input bit s,
                       input bit qr, output bit acc);
        @(negedge clk);
        din_valid_i = v;
        din_i       = W'(x);
        sync_i      = s;
        q_ready_i   = qr;
        acc = v && din_ready_o;
        if (acc) model_take(W'(x), s);
        else if (s) part.delete();
    endtask

    int stalls = 0;

    task automatic send(input int x, input bit s, input bit qr);
        bit acc;
        bit ss;
        ss = s;
        for (int t = 0; t < 40; t++) begin
            cyc(1'b1, x, ss, qr, acc);
            ss = 1'b0;
            if (acc) return;
            stalls++;
        end
        chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle(input bit qr);
        bit acc;
        cyc(1'b0, 0, 1'b0, qr, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn        = 1'b0;
        din_valid_i = 1'b0;
        sync_i      = 1'b0;
        part.delete();
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic grp_t outs();
        return {D3_o, D2_o, D1_o, D0_o};
    endfunction

    // Monitor: inputs settle after the falling edge; a handoff is due next edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                exp_cnt = '0;
            end else if (q_valid_o && q_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_group", 64'(outs()), 64'hDEAD);
                end else begin
                    chk("group", 64'(outs()), 64'(exp_q.pop_front()));
                end
                chk("grp_cnt", 64'(grp_cnt_o), 64'(exp_cnt));
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        @(negedge clk);
        #1;
        chk("rst_D", 64'(outs()), 64'd0);
        chk("rst_valid", 64'(q_valid_o), 64'd0);
        chk("rst_cnt", 64'(grp_cnt_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_ready", 64'(din_ready_o), 64'd1);

        // Stream 1..4
        send(1, 0, 1); send(2, 0, 1); send(3, 0, 1); send(4, 0, 1);
        @(posedge clk); #1;
        chk("stream_valid", 64'(q_valid_o), 64'd1);
        chk("stream_D", 64'(outs()), 64'(mk(1, 2, 3, 4)));
        idle(1);
        @(posedge clk); #1;
        chk("stream_cnt", 64'(grp_cnt_o), 64'd1);
        chk("stream_drain", 64'(q_valid_o), 64'd0);

        // Back-pressure: -5..2 with downstream stalled
        for (int i = -5; i <= 2; i++) send(i, 0, 0);
        @(posedge clk); #1;
        chk("bp_ready_low", 64'(din_ready_o), 64'd0);
        chk("bp_held", 64'(outs()), 64'(mk(-5, -4, -3, -2)));
        idle(1);
        @(posedge clk); #1;
        chk("bp_second", 64'(outs()), 64'(mk(-1, 0, 1, 2)));
        chk("bp_valid", 64'(q_valid_o), 64'd1);
        chk("bp_ready_back", 64'(din_ready_o), 64'd1);
        idle(1);

        // Sign and width
        send(127, 0, 1); send(-128, 0, 1); send(-1, 0, 1); send(0, 0, 1);
        @(posedge clk); #1;
        chk("sign_D", 64'(outs()), 64'h00FF807F);
        idle(1);

        // Realign
        send(10, 0, 1); send(11, 0, 1);
        send(20, 1, 1); send(21, 0, 1); send(22, 0, 1); send(23, 0, 1);
        @(posedge clk); #1;
        chk("sync_D", 64'(outs()), 64'(mk(20, 21, 22, 23)));
        idle(1);

        // Reset mid-operation
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
        send(5, 0, 0); send(6, 0, 0); send(7, 0, 0);
        @(negedge clk);
        rstn        = 1'b0;
        din_valid_i = 1'b0;
        part.delete();
        exp_q.delete();
        #1;
        chk("mid_rst_D", 64'(outs()), 64'd0);
        chk("mid_rst_valid", 64'(q_valid_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        send(40, 0, 1); send(41, 0, 1); send(42, 0, 1); send(43, 0, 1);
        @(posedge clk); #1;
        chk("post_rst_D", 64'(outs()), 64'(mk(40, 41, 42, 43)));
        idle(1);

        // Counter wrap: 17 back-to-back groups
        do_reset();
        stalls = 0;
        for (int i = 0; i < 68; i++) send(i * 3, 0, 1);
        idle(1);
        @(posedge clk); #1;
        chk("wrap_cnt", 64'(grp_cnt_o), 64'd1);
        chk("no_stalls", 64'(stalls), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 4) != 0, int'($urandom % 256),
                ($urandom % 20) == 0, ($urandom % 5) < 3, acc);
        end
        repeat (4) idle(1);
        @(negedge clk); #3;
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/sample_deinterleave_4out.md
Name: sample_deinterleave_4out

Overview:
- Serial-to-parallel lane distributor. It takes one signed sample stream and emits groups of four consecutive samples as four parallel lanes, D0 through D3.
- It is the producer side of the 4-input registered adder in the soc_system datapath. Lane outputs connect directly to that adder's D0..D3 inputs.
- Upstream uses a valid/ready handshake. Downstream uses a valid/ready handshake with one output register plus one staging group, so full throughput is sustained under back-pressure.

Parameters:
- WIDTH, 8, sample width in bits (two's complement).
- CNT_W, 16, width of the emitted-group counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- din_i  in  WIDTH  signed input sample.
- din_valid_i  in  1  din_i valid.
- din_ready_o  out  1  block can accept din_i this cycle.
- sync_i  in  1  realign: the next accepted sample becomes lane 0.
- D0_o  out  WIDTH  lane 0, the oldest sample of the group.
- D1_o  out  WIDTH  lane 1.
- D2_o  out  WIDTH  lane 2.
- D3_o  out  WIDTH  lane 3, the newest sample of the group.
- q_valid_o  out  1  D0_o..D3_o hold a complete group.
- q_ready_i  in  1  downstream accepts the group.
- grp_cnt_o  out  CNT_W  count of groups handed off; wraps to 0 after all ones.

Behaviour:
- Reset (rstn low, asynchronous): D0_o..D3_o = 0, q_valid_o = 0, grp_cnt_o = 0, lane counter = 0, staging registers = 0, stage_full = 0. din_ready_o = 1 once rstn is high.
- Reset mid-group or mid-handshake: the partial group and any held output are discarded, with no partial output.
- Accept: a sample is accepted when din_valid_i && din_ready_o at a rising edge.
  - din_ready_o = ~stage_full, from a register; there is no combinational path from q_ready_i.
- Lane counter (2 bits) selects the lane for each accepted sample.
  - Samples at lanes 0, 1 and 2 are written to staging lanes 0, 1 and 2; the counter increments.
  - Lane 3 completes the group; the counter wraps 3 to 0.
- Output slot is free when ~q_valid_o || q_ready_i.
- Group completion (4th sample accepted at edge N):
  - Slot free: D0_o..D2_o load from staging lanes 0..2 and D3_o loads din_i at edge N; q_valid_o = 1 after edge N. Latency from 4th sample to q_valid_o is 1 cycle.
  - Slot not free: staging lane 3 loads din_i and stage_full is set, so din_ready_o = 0.
- Staged transfer: when stage_full && slot free, staging lanes 0..3 load into D0_o..D3_o, q_valid_o stays 1, and stage_full clears. din_ready_o returns to 1 on the following cycle.
- Output hold: while q_valid_o && ~q_ready_i, D0_o..D3_o and q_valid_o are stable.
- Output drain: on q_valid_o && q_ready_i with no new load, q_valid_o clears.
- Group counter: grp_cnt_o increments by 1 on every q_valid_o && q_ready_i handshake.
- sync_i:
  - Without an accepted sample that cycle: lane counter goes to 0 and partial staging lanes are discarded.
  - With an accepted sample the same cycle: that sample is written to lane 0 and the counter goes to 1.
  - It does not affect stage_full, the output register or grp_cnt_o.
  - While stage_full, a sample cannot be accepted; sync still resets the counter.
- Arithmetic: there is none on data. Samples pass bit-exact, and the sign is preserved.
- Throughput: 1 sample per cycle sustained with q_ready_i held high. There are no bubbles between consecutive groups.

Test Plan:
- Reset then stream: feed 1,2,3,4 on consecutive cycles with q_ready_i = 1. Expect q_valid_o high one cycle after sample 4 with D0..D3 = 1,2,3,4; grp_cnt_o = 1 after the handshake.
- Back-pressure: q_ready_i = 0, stream 8 samples -5..2.
  - First group -5,-4,-3,-2 is held on the outputs; the second group is staged.
  - din_ready_o drops after the 8th sample.
  - Raise q_ready_i: first group is handed off, second group -1,0,1,2 appears the next cycle, and din_ready_o returns to 1.
- Sign and width: WIDTH = 8, samples 127, -128, -1, 0. Expect outputs 8'h7F, 8'h80, 8'hFF, 8'h00 exactly.
- Realign: after 2 samples 10 and 11, pulse sync_i together with sample 20, then send 21, 22, 23. Expect group 20,21,22,23; 10 and 11 never appear.
- Reset mid-operation: assert rstn low after 3 samples with a group held on the outputs. All outputs go to 0 and q_valid_o goes to 0 immediately. After release, 4 new samples form a fresh group starting at lane 0.
- Counter wrap: CNT_W = 4, complete 17 handshakes. Expect grp_cnt_o = 1, with a wrap at the 16th handshake.
